// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all input rows of a 1-output gate network and checks the measured truth table.
module truth_table_sweeper #(
    parameter int N_IN = 4,
    parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = 16'h0239,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        stim_o,
    input  logic                   dut_out_i,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_count,
    output logic                   fail_valid,
    output logic [N_IN-1:0]        first_fail_idx,
    output logic [(1<<N_IN)-1:0]   captured_tt
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
    state_t state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0] cnt;
    logic sync1, sync2;
    logic mm;
    logic [N_IN:0] next_count;
    // Row r lives at bit 2^N_IN-1-r, which is simply ~r over N_IN bits.
    assign mm = sync2 != TRUTH_TABLE[~idx];
    assign next_count = mismatch_count + (N_IN+1)'(mm);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            stim_o <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            mismatch_count <= '0;
            fail_valid <= 1'b0;
            first_fail_idx <= '0;
            captured_tt <= '0;
        end else begin
            sync1 <= dut_out_i;
            sync2 <= sync1;
            done <= 1'b0;
            if (busy && abort) begin
                state <= IDLE;
                busy <= 1'b0;
                pass <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= APPLY;
                        busy <= 1'b1;
                        idx <= '0;
                        pass <= 1'b0;
                        mismatch_count <= '0;
                        fail_valid <= 1'b0;
                        first_fail_idx <= '0;
                        captured_tt <= '0;
                    end
                    APPLY: begin
                        stim_o <= idx;
                        cnt <= CW'(SETTLE_CYCLES - 1);
                        state <= SETTLE;
                    end
                    SETTLE: begin
                        if (cnt == '0) state <= SAMPLE;
                        else cnt <= cnt - 1'b1;
                    end
                    SAMPLE: begin
                        captured_tt[~idx] <= sync2;
                        mismatch_count <= next_count;
                        if (mm && !fail_valid) begin
                            fail_valid <= 1'b1;
                            first_fail_idx <= idx;
                        end
                        if (&idx) begin
                            state <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= next_count == '0;
                        end else begin
                            idx <= idx + 1'b1;
                            state <= APPLY;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
